// File: rtl/exe_arb_pkg.sv
// Shared types and constants for the ALU arbiter slice.
// Holds the FSM state encoding, default datapath widths and flag bit positions.
package exe_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEF_M = 8;
    localparam int DEF_N = 4;
    localparam int DEF_F = 4;

    localparam int FLAG_OF = 0;
    localparam int FLAG_SF = 1;
    localparam int FLAG_BF = 2;
    localparam int FLAG_VF = 3;

endpackage

// File: rtl/exe_unit_arbiter_rr_picker.sv
// Round-robin picker: first set request searching cyclically from ptr+1.
// Latency: combinational. Backpressure: none, pure function of req and ptr.
// The previous winner sits at ptr, so it is considered last.
module rr_picker #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   idx
);

    logic          found;
    logic [PW-1:0] k;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        k     = '0;
        for (int i = 1; i <= NREQ; i++) begin
            k = PW'((int'(ptr) + i) % NREQ);
            if (!found && req[k]) begin
                found  = 1'b1;
                gnt[k] = 1'b1;
                idx    = k;
            end
        end
    end

endmodule

// File: rtl/exe_unit_arbiter.sv
// Round-robin arbiter/sequencer sharing one external ALU between NREQ requesters.
// Latency: grant 1 cycle after a request is seen in IDLE, done 1 cycle after that.
// Backpressure: one op per 3 cycles; requests seen outside IDLE are simply not sampled.
module exe_unit_arbiter
    import exe_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int M    = DEF_M,
    parameter int N    = DEF_N,
    parameter int F    = DEF_F,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic            i_clk_p,
    input  logic            i_rst,
    input  logic [NREQ-1:0] i_req,
    input  logic [NREQ*N-1:0] i_oper,
    input  logic [NREQ*M-1:0] i_argA,
    input  logic [NREQ*M-1:0] i_argB,
    output logic [NREQ-1:0] o_gnt,
    output logic [NREQ-1:0] o_done,
    output logic [M-1:0]    o_result,
    output logic [F-1:0]    o_flags,
    output logic            o_busy,
    output logic [N-1:0]    o_alu_oper,
    output logic [M-1:0]    o_alu_argA,
    output logic [M-1:0]    o_alu_argB,
    input  logic [M-1:0]    i_alu_result,
    input  logic [F-1:0]    i_alu_flags
);

    state_t          state, state_nxt;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;
    logic [NREQ-1:0] pick_gnt;
    logic [PW-1:0]   pick_idx;
    logic            any_req;

    rr_picker #(.NREQ(NREQ), .PW(PW)) u_picker (
        .req (i_req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    assign any_req = |i_req;
    assign o_busy  = (state != IDLE);

    always_ff @(posedge i_clk_p or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    // Any unused encoding falls through to IDLE on the next edge.
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = any_req ? EXEC : IDLE;
            EXEC:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk_p or posedge i_rst) begin
        if (i_rst) begin
            ptr        <= PW'(NREQ - 1);
            owner      <= '0;
            o_gnt      <= '0;
            o_done     <= '0;
            o_result   <= '0;
            o_flags    <= '0;
            o_alu_oper <= '0;
            o_alu_argA <= '0;
            o_alu_argB <= '0;
        end else begin
            o_gnt  <= '0;
            o_done <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner <= pick_idx;
                        o_gnt <= pick_gnt;
                        for (int k = 0; k < NREQ; k++) begin
                            if (pick_gnt[k]) begin
                                o_alu_oper <= i_oper[k*N +: N];
                                o_alu_argA <= i_argA[k*M +: M];
                                o_alu_argB <= i_argB[k*M +: M];
                            end
                        end
                    end
                end
                EXEC: begin
                    o_result <= i_alu_result;
                    o_flags  <= i_alu_flags;
                    o_done   <= {{(NREQ-1){1'b0}}, 1'b1} << owner;
                    ptr      <= owner;
                end
                default: ;
            endcase
        end
    end

endmodule
